// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit and its prediction queue.
package bru_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_BYTES  = 4;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic                    pred_taken;
    logic [XLEN_DEFAULT-1:0] pred_target;
  } bpq_entry_t;

endpackage

// File: rtl/bpq_fifo.sv
// In-order queue of outstanding branch predictions; clear discards every entry
// and wins over a same-cycle push or pop.
module bpq_fifo
  import bru_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = bpq_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CW      = PTR_W + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  entry_t        wr_data,
  output entry_t        rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full & ~clear;
  assign pop_ok  = pop & ~empty & ~clear;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers are PTR_W wide so the increment wraps modulo DEPTH on its own.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches EX branch outcomes against queued fetch predictions; drives predictor
// training, mispredict flush/redirect and branch statistics.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 32,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_fetch_valid,
  input  logic             i_fetch_is_branch,
  input  logic [XLEN-1:0]  i_fetch_pc,
  input  logic             i_fetch_pred_taken,
  input  logic [XLEN-1:0]  i_fetch_pred_target,
  output logic             o_fetch_stall,
  input  logic             i_ex_valid,
  input  logic             i_ex_taken,
  input  logic [XLEN-1:0]  i_ex_target,
  output logic             o_upd_valid,
  output logic [XLEN-1:0]  o_upd_pc,
  output logic             o_upd_taken,
  output logic             o_flush,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispredict_cnt,
  output logic             o_error
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } entry_t;

  entry_t          push_entry;
  entry_t          head;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;
  logic            push;
  logic            resolve;
  logic            mispredict;
  logic            clear;
  logic [XLEN-1:0] redirect;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign push_entry = '{pc: i_fetch_pc, pred_taken: i_fetch_pred_taken,
                        pred_target: i_fetch_pred_target};

  // A full queue refuses the push even if the head pops this cycle.
  assign o_fetch_stall = (q_count == CW'(DEPTH));
  assign push          = i_fetch_valid & i_fetch_is_branch & ~q_full;
  assign resolve       = i_ex_valid & ~q_empty;

  assign mispredict = (i_ex_taken != head.pred_taken) |
                      (i_ex_taken & head.pred_taken & (i_ex_target != head.pred_target));
  assign redirect   = i_ex_taken ? i_ex_target : head.pc + XLEN'(INSTR_BYTES);
  // Everything younger than a mispredicted branch is wrong-path.
  assign clear      = resolve & mispredict;

  bpq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (resolve),
    .clear   (clear),
    .wr_data (push_entry),
    .rd_data (head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  // Registered resolve outputs, one cycle after the EX resolve.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_upd_valid      <= 1'b0;
      o_upd_pc         <= '0;
      o_upd_taken      <= 1'b0;
      o_flush          <= 1'b0;
      o_redirect_pc    <= '0;
      o_branch_cnt     <= '0;
      o_mispredict_cnt <= '0;
      o_error          <= 1'b0;
    end else begin
      o_upd_valid <= resolve;
      o_flush     <= clear;
      if (resolve) begin
        o_upd_pc     <= head.pc;
        o_upd_taken  <= i_ex_taken;
        o_branch_cnt <= sat_inc(o_branch_cnt);
      end
      if (clear) begin
        o_redirect_pc    <= redirect;
        o_mispredict_cnt <= sat_inc(o_mispredict_cnt);
      end
      if (i_ex_valid && q_empty) o_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference queue model predicts each
// cycle's registered outputs, which are compared one cycle later.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_fetch_valid, i_fetch_is_branch, i_fetch_pred_taken;
  logic [XLEN-1:0]  i_fetch_pc, i_fetch_pred_target;
  logic             o_fetch_stall;
  logic             i_ex_valid, i_ex_taken;
  logic [XLEN-1:0]  i_ex_target;
  logic             o_upd_valid, o_upd_taken, o_flush, o_error;
  logic [XLEN-1:0]  o_upd_pc, o_redirect_pc;
  logic [CNT_W-1:0] o_branch_cnt, o_mispredict_cnt;

  branch_resolve_unit #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_fetch_valid(i_fetch_valid), .i_fetch_is_branch(i_fetch_is_branch),
    .i_fetch_pc(i_fetch_pc), .i_fetch_pred_taken(i_fetch_pred_taken),
    .i_fetch_pred_target(i_fetch_pred_target), .o_fetch_stall(o_fetch_stall),
    .i_ex_valid(i_ex_valid), .i_ex_taken(i_ex_taken), .i_ex_target(i_ex_target),
    .o_upd_valid(o_upd_valid), .o_upd_pc(o_upd_pc), .o_upd_taken(o_upd_taken),
    .o_flush(o_flush), .o_redirect_pc(o_redirect_pc),
    .o_branch_cnt(o_branch_cnt), .o_mispredict_cnt(o_mispredict_cnt),
    .o_error(o_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        tk;
    logic        fl;
  } exp_t;

  ent_t        mq[$];
  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_bcnt, m_mcnt, m_red;
  logic        m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    chk("error", 64'(o_error), 64'(m_err));
    chk("branch_cnt", 64'(o_branch_cnt), 64'(m_bcnt));
    chk("mispred_cnt", 64'(o_mispredict_cnt), 64'(m_mcnt));
    chk("redirect_pc", 64'(o_redirect_pc), 64'(m_red));
    chk("count", 64'(dut.u_fifo.count), 64'(mq.size()));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_fetch_valid = 0; i_fetch_is_branch = 0; i_fetch_pc = '0;
    i_fetch_pred_taken = 0; i_fetch_pred_target = '0;
    i_ex_valid = 0; i_ex_taken = 0; i_ex_target = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    mq.delete(); sb.delete();
    m_bcnt = '0; m_mcnt = '0; m_red = '0; m_err = 1'b0;
    chk("rst_upd_valid", 64'(o_upd_valid), 64'd0);
    chk("rst_upd_pc", 64'(o_upd_pc), 64'd0);
    chk("rst_upd_taken", 64'(o_upd_taken), 64'd0);
    chk("rst_flush", 64'(o_flush), 64'd0);
    chk("rst_stall", 64'(o_fetch_stall), 64'd0);
    check_state();
  endtask

  // One clock: drive inputs, predict, advance, compare.
  task automatic step(input logic fv, input logic [31:0] pc, input logic pt,
                      input logic [31:0] ptgt, input logic exv, input logic ext,
                      input logic [31:0] extgt);
    exp_t e;
    ent_t h, n;
    logic full, res, mis;
    i_fetch_valid = fv; i_fetch_is_branch = fv; i_fetch_pc = pc;
    i_fetch_pred_taken = pt; i_fetch_pred_target = ptgt;
    i_ex_valid = exv; i_ex_taken = ext; i_ex_target = extgt;
    full = (mq.size() == DEPTH);
    chk("fetch_stall", 64'(o_fetch_stall), 64'(full));
    res = exv && (mq.size() > 0);
    mis = 1'b0;
    e = '{v: res, pc: '0, tk: ext, fl: 1'b0};
    if (res) begin
      h = mq.pop_front();
      mis = (ext != h.pt) || (ext && h.pt && extgt != h.tgt);
      e.pc = h.pc;
      e.fl = mis;
      m_bcnt = (m_bcnt == '1) ? m_bcnt : m_bcnt + 1;
      if (mis) begin
        m_mcnt = (m_mcnt == '1) ? m_mcnt : m_mcnt + 1;
        m_red  = ext ? extgt : h.pc + 32'd4;
        mq.delete();
      end
    end
    if (exv && !res) m_err = 1'b1;
    if (fv && !full && !mis) begin
      n = '{pc: pc, pt: pt, tgt: ptgt};
      mq.push_back(n);
    end
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("upd_valid", 64'(o_upd_valid), 64'(e.v));
    if (e.v) begin
      chk("upd_pc", 64'(o_upd_pc), 64'(e.pc));
      chk("upd_taken", 64'(o_upd_taken), 64'(e.tk));
    end
    chk("flush", 64'(o_flush), 64'(e.fl));
    check_state();
  endtask

  task automatic push_br(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    step(1, pc, pt, tgt, 0, 0, '0);
  endtask

  task automatic resolve_br(input logic tk, input logic [31:0] tgt);
    step(0, '0, 0, '0, 1, tk, tgt);
  endtask

  task automatic idle();
    step(0, '0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    do_reset();

    // correct not-taken prediction
    push_br(32'h100, 0, 32'h0);
    resolve_br(0, 32'h0);
    idle();

    // direction mispredict discards the younger entry
    push_br(32'h200, 0, 32'h0);
    push_br(32'h240, 0, 32'h0);
    resolve_br(1, 32'h80);
    chk("redirect_0x80", 64'(o_redirect_pc), 64'h80);
    idle();

    // target mispredict, then not-taken redirect wrapping past 2^32
    push_br(32'h280, 1, 32'h300);
    resolve_br(1, 32'h304);
    chk("redirect_0x304", 64'(o_redirect_pc), 64'h304);
    push_br(32'hFFFF_FFFC, 1, 32'h10);
    resolve_br(0, 32'h0);
    chk("redirect_wrap", 64'(o_redirect_pc), 64'h0);
    idle();

    // fill the queue; a push alongside a correct resolve is refused while full
    for (int i = 0; i < DEPTH; i++) push_br(32'h400 + 32'(i * 16), 0, 32'h0);
    step(1, 32'h500, 0, 32'h0, 1, 0, '0);
    chk("count_after_refuse", 64'(dut.u_fifo.count), 64'd3);
    push_br(32'h500, 0, 32'h0);
    for (int i = 0; i < DEPTH; i++) resolve_br(0, '0);
    idle();

    // mispredict drops the same-cycle push; next resolve hits an empty queue
    push_br(32'h600, 0, 32'h0);
    step(1, 32'h640, 0, 32'h0, 1, 1, 32'h700);
    resolve_br(0, '0);
    idle();

    // reset with entries outstanding
    do_reset();
    push_br(32'h800, 0, 32'h0);
    push_br(32'h804, 1, 32'h900);
    push_br(32'h808, 0, 32'h0);
    do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), {$urandom, 2'b00} & 32'hFFFF_FFFC,
           1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 1) * 4),
           ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
           32'h1000 + 32'($urandom_range(0, 1) * 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the fetch-stage 2-bit predictor interface.
- Records each prediction made at fetch in an in-order queue, pops the oldest entry when that branch resolves in EX, and compares prediction with outcome.
- Produces the predictor update strobe (pc, actual taken), the pipeline flush and redirect PC on mispredict, and branch/mispredict statistics.

Parameters:
- DEPTH, 4, number of in-flight branch predictions tracked (power of 2, ≥2).
- XLEN, 32, PC/target width.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- i_fetch_valid  in  1  fetch stage holds a valid instruction this cycle.
- i_fetch_is_branch  in  1  that instruction is a conditional branch.
- i_fetch_pc  in  XLEN  PC of fetched branch.
- i_fetch_pred_taken  in  1  predictor output for i_fetch_pc.
- i_fetch_pred_target  in  XLEN  target fetch will follow if predicted taken.
- o_fetch_stall  out  1  queue full; fetch must hold the branch.
- i_ex_valid  in  1  a branch resolves in EX this cycle (oldest outstanding).
- i_ex_taken  in  1  actual direction.
- i_ex_target  in  XLEN  actual taken target.
- o_upd_valid  out  1  predictor update strobe.
- o_upd_pc  out  XLEN  PC to update.
- o_upd_taken  out  1  actual outcome to train with.
- o_flush  out  1  squash IF/ID, one-cycle pulse.
- o_redirect_pc  out  XLEN  correct fetch PC, valid with o_flush.
- o_branch_cnt  out  CNT_W  resolved branches.
- o_mispredict_cnt  out  CNT_W  mispredicted branches.
- o_error  out  1  sticky: resolve with empty queue.

Behaviour:
- Reset (rst=0 at posedge): queue empty (rd/wr ptr = 0, count = 0); all outputs 0; counters 0; o_error 0. Reset mid-operation discards all entries immediately.
- Entry = {pc, pred_taken, pred_target}.
- Push: i_fetch_valid & i_fetch_is_branch & count<DEPTH. Entry is written at the posedge.
- o_fetch_stall is combinational and equals (count==DEPTH). When full, push is refused even if a pop occurs in the same cycle; fetch retries next cycle.
- Resolve, when i_ex_valid & count>0:
  - Pop head.
  - mispredict = (i_ex_taken != head.pred_taken) | (i_ex_taken & head.pred_taken & i_ex_target != head.pred_target).
  - redirect = i_ex_taken ? i_ex_target : head.pc + 4 (modulo 2^XLEN, wraps).
- Outputs are registered, latency 1 cycle after resolve:
  - o_upd_valid=1, o_upd_pc=head.pc, o_upd_taken=i_ex_taken for every resolve.
  - o_flush=1 and o_redirect_pc=redirect only on mispredict.
  - All strobes deassert the next cycle unless another resolve occurs.
- Mispredict clears the queue at the same edge: all younger entries are wrong-path. A push presented in the same cycle is dropped.
- Correct resolve and push in the same cycle: both occur, count unchanged.
- Pointers wrap modulo DEPTH.
- Resolve with empty queue: no pop, no o_upd_valid, no flush; o_error set and held until reset.
- Counters: o_branch_cnt +1 per valid resolve; o_mispredict_cnt +1 per mispredict. Both saturate at all-ones (no wrap).
- o_redirect_pc holds its last value when o_flush=0.

Decomposition:
- Shared package bru_pkg:
  - bpq_entry_t struct (pc, pred_taken, pred_target).
  - INSTR_BYTES = 4 constant.
  - XLEN default.
- One sub-module: bpq_fifo, a synchronous FIFO with push, pop, clear and full/empty/count outputs, sized by DEPTH.
- Compare, redirect and counter logic stays in the top module.

Test Plan:
- Correct prediction: push pc=0x100 pred_taken=0; resolve taken=0 → next cycle o_upd_valid=1, o_upd_pc=0x100, o_upd_taken=0, o_flush=0, branch_cnt=1, mispredict_cnt=0.
- Direction mispredict: push pc=0x200 pred_taken=0, push pc=0x240; resolve taken=1 target=0x80 → o_flush=1, o_redirect_pc=0x80, queue empty after (0x240 discarded), mispredict_cnt=1.
- Target mispredict and not-taken redirect:
  - pred_taken=1 target=0x300, actual taken target=0x304 → flush, redirect 0x304.
  - pred_taken=1, actual not taken at pc=0xFFFFFFFC → redirect 0x00000000 (wrap).
- Full: push 4 branches → o_fetch_stall=1; 5th push with simultaneous correct resolve is refused (count 3 after); next-cycle push accepted.
- Flush vs push: mispredicting resolve plus push in the same cycle → pushed entry dropped, count=0; a following resolve sets o_error=1 with no o_upd_valid.
- Reset mid-operation: 3 entries queued, rst=0 for one cycle → count=0, all outputs 0, counters 0, o_error 0.
